// File: rtl/mem_arb2_pkg.sv
// Shared definitions for the two-master picorv32 native-bus arbiter.
package mem_arb2_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  // Read data handed back to a master whose access timed out.
  localparam logic [DATA_W-1:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

  // Arbiter state; the state register alone selects the bus owner.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb2_if.sv
// picorv32 native memory bus bundle.
// Handshake: the requester raises valid with instr/addr/wdata/wstrb stable and
// holds them until the responder returns ready for exactly one cycle; rdata is
// meaningful only in that ready cycle. wstrb == 0 means read.
interface mem_arb2_if;
  import mem_arb2_pkg::*;

  logic              valid;
  logic              instr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              ready;
  logic [DATA_W-1:0] rdata;

  // Requester side (the CPU, or the arbiter towards the decoder).
  modport master (
    output valid, instr, addr, wdata, wstrb,
    input  ready, rdata
  );

  // Responder side (the decoder, or the arbiter towards each master).
  modport slave (
    input  valid, instr, addr, wdata, wstrb,
    output ready, rdata
  );

endinterface

// File: rtl/mem_arb2_bus_watchdog.sv
// Bus watchdog: counts unanswered cycles of the granted access, flags expiry
// in the cycle the count reaches TIMEOUT-1, and keeps a saturating error count.
module mem_arb2_bus_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        run,
  output logic        expire,
  output logic [15:0] err_count
);

  localparam int            CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;
  logic [15:0]   r_err;

  // Expiry only while still waiting; a same-cycle ready wins over the timeout.
  assign expire    = run & (r_cnt == LIMIT);
  assign err_count = r_err;

  // Wait counter: cleared when the access ends or the bus is not granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear || expire) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Saturating timeout counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= '0;
    end else if (expire && (r_err != 16'hFFFF)) begin
      r_err <= r_err + 16'd1;
    end
  end

endmodule

// File: rtl/mem_arb2.sv
// Two-master round-robin arbiter for the picorv32 native memory bus.
// Master 0 is the CPU, master 1 a secondary requester; the grant is held until
// the transfer completes, the master withdraws, or the watchdog expires.
module mem_arb2
  import mem_arb2_pkg::*;
#(
  parameter int                TIMEOUT   = 1024,
  parameter logic [DATA_W-1:0] ERR_RDATA = ERR_RDATA_DEF
) (
  input  logic         clk,
  input  logic         reset,
  mem_arb2_if.slave    m0,
  mem_arb2_if.slave    m1,
  mem_arb2_if.master   s,
  output logic [1:0]   grant,
  output logic         bus_err,
  output logic [15:0]  err_count,
  output arb_state_t   dbg_state
);

  arb_state_t r_state;
  logic       r_last;
  logic [1:0] r_grant;

  logic w_sel0;
  logic w_sel1;
  logic w_req_valid;
  logic w_run;
  logic w_done;
  logic w_drop;
  logic w_clear;
  logic w_expire;

  assign w_sel0      = (r_state == ST_G0);
  assign w_sel1      = (r_state == ST_G1);
  assign w_req_valid = w_sel0 ? m0.valid : (w_sel1 ? m1.valid : 1'b0);
  assign w_run       = w_req_valid & ~s.ready;
  assign w_done      = w_req_valid & s.ready;
  assign w_drop      = (w_sel0 | w_sel1) & ~w_req_valid;
  assign w_clear     = ~(w_sel0 | w_sel1) | w_done | w_drop;

  mem_arb2_bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_clear),
    .run       (w_run),
    .expire    (w_expire),
    .err_count (err_count)
  );

  // Slave-side request mux; valid is killed in the expiry cycle so the
  // abandoned access (and any write) never reaches the decoder as complete.
  assign s.valid = w_req_valid & ~w_expire;
  assign s.instr = w_sel0 ? m0.instr : (w_sel1 ? m1.instr : 1'b0);
  assign s.addr  = w_sel0 ? m0.addr  : (w_sel1 ? m1.addr  : '0);
  assign s.wdata = w_sel0 ? m0.wdata : (w_sel1 ? m1.wdata : '0);
  assign s.wstrb = w_sel0 ? m0.wstrb : (w_sel1 ? m1.wstrb : '0);

  // Response demux; the non-granted master sees ready=0 and rdata=0.
  assign m0.ready = w_sel0 & (w_done | w_expire);
  assign m1.ready = w_sel1 & (w_done | w_expire);
  assign m0.rdata = w_sel0 ? (w_expire ? ERR_RDATA : s.rdata) : '0;
  assign m1.rdata = w_sel1 ? (w_expire ? ERR_RDATA : s.rdata) : '0;

  assign bus_err   = w_expire;
  assign grant     = r_grant;
  assign dbg_state = r_state;

  // Arbitration FSM: round-robin pick in IDLE, hold grant until the access ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_grant <= 2'b00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (m0.valid && (!m1.valid || r_last)) begin
            r_state <= ST_G0;
            r_grant <= 2'b01;
          end else if (m1.valid) begin
            r_state <= ST_G1;
            r_grant <= 2'b10;
          end
        end
        ST_G0: begin
          if (!m0.valid) begin
            r_state <= ST_IDLE;
            r_grant <= 2'b00;
          end else if (w_done || w_expire) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b0;
            r_grant <= 2'b00;
          end
        end
        ST_G1: begin
          if (!m1.valid) begin
            r_state <= ST_IDLE;
            r_grant <= 2'b00;
          end else if (w_done || w_expire) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_grant <= 2'b00;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb2.sv
// Directed testbench for mem_arb2 with a short watchdog (TIMEOUT=8).
module tb_mem_arb2;
  import mem_arb2_pkg::*;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  grant;
  logic        bus_err;
  logic [15:0] err_count;
  arb_state_t  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arb2_if m0_bus ();
  mem_arb2_if m1_bus ();
  mem_arb2_if s_bus ();

  mem_arb2 #(
    .TIMEOUT   (TIMEOUT),
    .ERR_RDATA (32'hDEAD_BEEF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .s         (s_bus),
    .grant     (grant),
    .bus_err   (bus_err),
    .err_count (err_count),
    .dbg_state (dbg_state)
  );

  // Clock / time limit
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL time_limit: simulation did not finish, got running expected done");
    $fatal(1);
  end

  // Driver tasks: inputs change at the falling edge, checks follow #1 later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_all();
    m0_bus.valid = 1'b0; m0_bus.instr = 1'b0; m0_bus.addr = '0; m0_bus.wdata = '0; m0_bus.wstrb = '0;
    m1_bus.valid = 1'b0; m1_bus.instr = 1'b0; m1_bus.addr = '0; m1_bus.wdata = '0; m1_bus.wstrb = '0;
    s_bus.ready = 1'b0; s_bus.rdata = '0;
  endtask

  task automatic pulse_reset();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_all();
    step();
    #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rst_grant: got %b expected 00", grant); end
    n_checks++; if (s_bus.valid !== 1'b0) begin n_fail++; $display("FAIL rst_s_valid: got %b expected 0", s_bus.valid); end
    n_checks++; if ({m1_bus.ready, m0_bus.ready} !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b expected 00", {m1_bus.ready, m0_bus.ready}); end
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_bus_err: got %b expected 0", bus_err); end
    n_checks++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL rst_err_count: got %0d expected 0", err_count); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_m0_read();
    step();
    m0_bus.valid = 1'b1; m0_bus.addr = 32'h0000_0100; m0_bus.wstrb = 4'b0000;
    #1;
    n_checks++; if (s_bus.valid !== 1'b0) begin n_fail++; $display("FAIL rd_latency: s_valid got %b expected 0", s_bus.valid); end
    step(); #1;
    n_checks++; if (s_bus.valid !== 1'b1) begin n_fail++; $display("FAIL rd_s_valid: got %b expected 1", s_bus.valid); end
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL rd_grant: got %b expected 01", grant); end
    n_checks++; if (s_bus.addr !== 32'h0000_0100) begin n_fail++; $display("FAIL rd_s_addr: got %h expected 00000100", s_bus.addr); end
    step(); #1;
    n_checks++; if (m0_bus.ready !== 1'b0) begin n_fail++; $display("FAIL rd_early_ready: got %b expected 0", m0_bus.ready); end
    step();
    s_bus.ready = 1'b1; s_bus.rdata = 32'h1234_5678;
    #1;
    n_checks++; if (m0_bus.ready !== 1'b1) begin n_fail++; $display("FAIL rd_m0_ready: got %b expected 1", m0_bus.ready); end
    n_checks++; if (m0_bus.rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_m0_rdata: got %h expected 12345678", m0_bus.rdata); end
    n_checks++; if (m1_bus.ready !== 1'b0) begin n_fail++; $display("FAIL rd_m1_ready: got %b expected 0", m1_bus.ready); end
    n_checks++; if (m1_bus.rdata !== 32'h0) begin n_fail++; $display("FAIL rd_m1_rdata: got %h expected 00000000", m1_bus.rdata); end
    step();
    m0_bus.valid = 1'b0; s_bus.ready = 1'b0;
    #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rd_back_idle: got %b expected 00", grant); end
    n_checks++; if (m0_bus.ready !== 1'b0) begin n_fail++; $display("FAIL rd_ready_after: got %b expected 0", m0_bus.ready); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_grant;
    int m0_done;
    int m1_done;
    m0_done = 0;
    m1_done = 0;
    pulse_reset();
    m0_bus.valid = 1'b1; m0_bus.addr = 32'h0000_1000;
    m1_bus.valid = 1'b1; m1_bus.addr = 32'h0000_2000;
    s_bus.ready = 1'b1; s_bus.rdata = 32'h0BAD_F00D;
    for (int i = 0; i < 16; i++) begin
      step();
      if (m0_done == 4) m0_bus.valid = 1'b0;
      if (m1_done == 4) m1_bus.valid = 1'b0;
      #1;
      exp_grant = (i % 4 == 0) ? 2'b01 : ((i % 4 == 2) ? 2'b10 : 2'b00);
      n_checks++; if (grant !== exp_grant) begin n_fail++; $display("FAIL b2b_grant[%0d]: got %b expected %b", i, grant, exp_grant); end
      if (m0_bus.ready === 1'b1) m0_done++;
      if (m1_bus.ready === 1'b1) m1_done++;
    end
    n_checks++; if (m0_done != 4) begin n_fail++; $display("FAIL b2b_m0_count: got %0d expected 4", m0_done); end
    n_checks++; if (m1_done != 4) begin n_fail++; $display("FAIL b2b_m1_count: got %0d expected 4", m1_done); end
    idle_all();
  endtask

  task automatic test_m1_write();
    step();
    m1_bus.valid = 1'b1; m1_bus.addr = 32'h0001_E000; m1_bus.wdata = 32'h0000_0041; m1_bus.wstrb = 4'b0001;
    step();
    m0_bus.valid = 1'b1; m0_bus.addr = 32'h0000_0200; m0_bus.wstrb = 4'b0000;
    #1;
    n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL wr_grant: got %b expected 10", grant); end
    n_checks++; if (s_bus.addr !== 32'h0001_E000) begin n_fail++; $display("FAIL wr_s_addr: got %h expected 0001e000", s_bus.addr); end
    n_checks++; if (s_bus.wdata !== 32'h0000_0041) begin n_fail++; $display("FAIL wr_s_wdata: got %h expected 00000041", s_bus.wdata); end
    n_checks++; if (s_bus.wstrb !== 4'b0001) begin n_fail++; $display("FAIL wr_s_wstrb: got %b expected 0001", s_bus.wstrb); end
    step();
    s_bus.ready = 1'b1;
    #1;
    n_checks++; if (m1_bus.ready !== 1'b1) begin n_fail++; $display("FAIL wr_m1_ready: got %b expected 1", m1_bus.ready); end
    n_checks++; if (m0_bus.ready !== 1'b0) begin n_fail++; $display("FAIL wr_m0_blocked: got %b expected 0", m0_bus.ready); end
    step();
    m1_bus.valid = 1'b0; s_bus.ready = 1'b0;
    #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL wr_bubble: got %b expected 00", grant); end
    n_checks++; if (s_bus.valid !== 1'b0) begin n_fail++; $display("FAIL wr_bubble_valid: got %b expected 0", s_bus.valid); end
    step(); #1;
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL wr_m0_next: got %b expected 01", grant); end
    n_checks++; if (s_bus.addr !== 32'h0000_0200) begin n_fail++; $display("FAIL wr_m0_addr: got %h expected 00000200", s_bus.addr); end
    step();
    s_bus.ready = 1'b1; s_bus.rdata = 32'h0000_0077;
    #1;
    n_checks++; if (m0_bus.rdata !== 32'h0000_0077) begin n_fail++; $display("FAIL wr_m0_rdata: got %h expected 00000077", m0_bus.rdata); end
    step();
    idle_all();
  endtask

  task automatic test_timeout();
    step();
    m0_bus.valid = 1'b1; m0_bus.addr = 32'h3000_0000; m0_bus.wstrb = 4'b0000;
    for (int k = 1; k <= TIMEOUT; k++) begin
      step(); #1;
      if (k < TIMEOUT) begin
        if (s_bus.valid !== 1'b1 || m0_bus.ready !== 1'b0 || bus_err !== 1'b0) begin
          n_fail++;
          $display("FAIL to_wait[%0d]: got valid/ready/err %b%b%b expected 100", k, s_bus.valid, m0_bus.ready, bus_err);
        end
        n_checks++;
      end
    end
    n_checks++; if (m0_bus.ready !== 1'b1) begin n_fail++; $display("FAIL to_ready: got %b expected 1", m0_bus.ready); end
    n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL to_bus_err: got %b expected 1", bus_err); end
    n_checks++; if (m0_bus.rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL to_rdata: got %h expected deadbeef", m0_bus.rdata); end
    n_checks++; if (s_bus.valid !== 1'b0) begin n_fail++; $display("FAIL to_s_valid_kill: got %b expected 0", s_bus.valid); end
    step();
    m0_bus.valid = 1'b0;
    #1;
    n_checks++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL to_err_count: got %0d expected 1", err_count); end
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL to_err_pulse: got %b expected 0", bus_err); end
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL to_idle: got %b expected 00", grant); end
  endtask

  task automatic test_late_ready();
    step();
    m0_bus.valid = 1'b1; m0_bus.addr = 32'h0000_0400;
    for (int k = 1; k < TIMEOUT; k++) step();
    step();
    s_bus.ready = 1'b1; s_bus.rdata = 32'hCAFE_0001;
    #1;
    n_checks++; if (m0_bus.ready !== 1'b1) begin n_fail++; $display("FAIL late_ready: got %b expected 1", m0_bus.ready); end
    n_checks++; if (m0_bus.rdata !== 32'hCAFE_0001) begin n_fail++; $display("FAIL late_rdata: got %h expected cafe0001", m0_bus.rdata); end
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL late_bus_err: got %b expected 0", bus_err); end
    n_checks++; if (s_bus.valid !== 1'b1) begin n_fail++; $display("FAIL late_s_valid: got %b expected 1", s_bus.valid); end
    step();
    m0_bus.valid = 1'b0; s_bus.ready = 1'b0;
    #1;
    n_checks++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL late_err_count: got %0d expected 1", err_count); end
  endtask

  task automatic test_reset_mid();
    step();
    m1_bus.valid = 1'b1; m1_bus.addr = 32'h0000_0800;
    step(); #1;
    n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL rm_grant_pre: got %b expected 10", grant); end
    #1;
    reset = 1'b1;
    #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rm_grant_async: got %b expected 00", grant); end
    n_checks++; if (s_bus.valid !== 1'b0) begin n_fail++; $display("FAIL rm_s_valid_async: got %b expected 0", s_bus.valid); end
    n_checks++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL rm_err_count: got %0d expected 0", err_count); end
    step();
    reset = 1'b0;
    m0_bus.valid = 1'b1; m0_bus.addr = 32'h0000_0900;
    #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rm_grant_release: got %b expected 00", grant); end
    step(); #1;
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL rm_m0_first: got %b expected 01", grant); end
    n_checks++; if (m1_bus.ready !== 1'b0) begin n_fail++; $display("FAIL rm_m1_ready: got %b expected 0", m1_bus.ready); end
    step();
    idle_all();
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_m0_read();
    test_back_to_back();
    test_m1_write();
    test_timeout();
    test_late_ready();
    test_reset_mid();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
